// File: rtl/spi_reg_pkg.sv
// ============================================================================
// Module      : spi_reg_pkg
// Description : Shared constants and types for the SPI register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;
    localparam int CNT_BITS   = 5;

    // Bit counter parks here once a frame carries more bits than a legal one.
    localparam logic [CNT_BITS-1:0] CNT_OVERRUN = 5'd17;

    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// Module      : sync_ff
// Description : Multi-stage flop synchroniser with configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_register_file.sv
// ============================================================================
// Module      : spi_register_file
// Description : Write-only SPI target driving the five PWM control registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_register_file
    import spi_reg_pkg::*;
#(
    parameter int                   SYNC_STAGES = 2,
    parameter logic [ADDR_BITS-1:0] MAX_ADDR    = 7'h04
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 ncs,
    input  logic                 copi,
    output logic [DATA_BITS-1:0] en_reg_out_7_0,
    output logic [DATA_BITS-1:0] en_reg_out_15_8,
    output logic [DATA_BITS-1:0] en_reg_pwm_7_0,
    output logic [DATA_BITS-1:0] en_reg_pwm_15_8,
    output logic [DATA_BITS-1:0] pwm_duty_cycle,
    output logic                 reg_wr_pulse
);

    logic w_sclk_s, w_ncs_s, w_copi_s;
    logic r_sclk_d, r_ncs_d;
    logic w_sclk_rise, w_ncs_fall, w_ncs_rise;

    spi_state_t r_state, w_next_state;
    logic [CNT_BITS-1:0]   r_count;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  w_commit;

    logic [ADDR_BITS-1:0]  w_addr;
    logic [DATA_BITS-1:0]  w_data;
    logic                  w_is_write;

    logic [DATA_BITS-1:0]  r_en_out_lo, r_en_out_hi;
    logic [DATA_BITS-1:0]  r_en_pwm_lo, r_en_pwm_hi;
    logic [DATA_BITS-1:0]  r_duty;
    logic                  r_wr_pulse;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sclk),
        .dout (w_sclk_s)
    );

    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ncs),
        .dout (w_ncs_s)
    );

    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (copi),
        .dout (w_copi_s)
    );

    // Edge-detect flops reset to the same idle levels as their synchronisers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d <= 1'b0;
            r_ncs_d  <= 1'b1;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ncs_d  <= w_ncs_s;
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;

    assign w_is_write = r_shift[FRAME_BITS-1];
    assign w_addr     = r_shift[FRAME_BITS-2 -: ADDR_BITS];
    assign w_data     = r_shift[DATA_BITS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_ncs_rise) begin
                    w_next_state = ST_IDLE;
                    w_commit     = (r_count == CNT_BITS'(FRAME_BITS)) &&
                                   w_is_write && (w_addr <= MAX_ADDR);
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A final sclk edge coincident with the ncs rise is deliberately dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_ncs_fall) begin
                r_count <= '0;
                r_shift <= '0;
            end
        end else if (w_sclk_rise && !w_ncs_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_s};
            if (r_count != CNT_OVERRUN) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out_lo <= '0;
            r_en_out_hi <= '0;
            r_en_pwm_lo <= '0;
            r_en_pwm_hi <= '0;
            r_duty      <= '0;
            r_wr_pulse  <= 1'b0;
        end else begin
            r_wr_pulse <= w_commit;
            if (w_commit) begin
                case (w_addr)
                    ADDR_EN_OUT_7_0:  r_en_out_lo <= w_data;
                    ADDR_EN_OUT_15_8: r_en_out_hi <= w_data;
                    ADDR_EN_PWM_7_0:  r_en_pwm_lo <= w_data;
                    ADDR_EN_PWM_15_8: r_en_pwm_hi <= w_data;
                    ADDR_PWM_DUTY:    r_duty      <= w_data;
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = r_en_out_lo;
    assign en_reg_out_15_8 = r_en_out_hi;
    assign en_reg_pwm_7_0  = r_en_pwm_lo;
    assign en_reg_pwm_15_8 = r_en_pwm_hi;
    assign pwm_duty_cycle  = r_duty;
    assign reg_wr_pulse    = r_wr_pulse;

endmodule

`default_nettype wire

// File: tb/tb_spi_register_file.sv
// ============================================================================
// Module      : tb_spi_register_file
// Description : Scoreboard bench driving async SPI frames into the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_register_file;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, ncs, copi;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       reg_wr_pulse;
    logic [39:0] dut_regs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model [5];
    logic [39:0] exp_q [$];

    always #5 clk = ~clk;

    spi_register_file dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sclk           (sclk),
        .ncs            (ncs),
        .copi           (copi),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .reg_wr_pulse   (reg_wr_pulse)
    );

    assign dut_regs = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                       en_reg_pwm_15_8, pwm_duty_cycle};

    function automatic logic [39:0] model_pack();
        return {model[0], model[1], model[2], model[3], model[4]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin changes land a random few ns after a clk edge, so phases vary per call.
    task automatic pin_delay(input int cycles);
        repeat (cycles) @(posedge clk);
        #($urandom_range(1, 8));
    endtask

    task automatic begin_frame(input int half);
        ncs = 1'b0;
        pin_delay(half);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            copi = val[i];
            pin_delay(half);
            sclk = 1'b1;
            pin_delay(half);
            sclk = 1'b0;
        end
    endtask

    task automatic end_frame(input logic exp_commit, input int half);
        pin_delay(half);
        ncs = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("pulse_early", reg_wr_pulse, 1'b0);
        @(posedge clk);
        #1 check("pulse_at_3_edges", reg_wr_pulse, exp_commit);
        pin_delay(2);
    endtask

    task automatic send_frame(input logic [31:0] val, input int n, input int half);
        logic       commit;
        logic [6:0] addr;
        addr   = val[14:8];
        commit = (n == 16) && val[15] && (addr <= 7'h04);
        if (commit) begin
            model[addr] = val[7:0];
            exp_q.push_back(model_pack());
        end
        begin_frame(half);
        send_bits(val, n, half);
        end_frame(commit, half);
        check("regs_after_frame", dut_regs, model_pack());
    endtask

    // Monitor: every commit pulse must match the next queued register snapshot.
    always @(negedge clk) begin
        if (rst_n && reg_wr_pulse) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got regs %h expected no commit at %0t",
                         dut_regs, $time);
            end else begin
                check("commit_regs", dut_regs, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation timed out at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f16;
        logic [31:0] fr;
        int          nb, half;

        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        rst_n = 1'b0;
        sclk  = 1'b0;
        ncs   = 1'b1;
        copi  = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("reset_regs", {dut_regs, reg_wr_pulse}, 41'h0);
        #2 rst_n = 1'b1;
        pin_delay(4);

        send_frame(32'h8001, 16, 4);
        send_frame(32'h81F0, 16, 5);
        send_frame(32'h8255, 16, 6);
        send_frame(32'h83AA, 16, 4);
        send_frame(32'h8480, 16, 8);

        send_frame(32'h04FF, 16, 4);
        send_frame(32'h85FF, 16, 4);
        send_frame(32'h0041FF >> 1, 15, 4);
        send_frame({15'h0, 16'h8433, 1'b1}, 17, 4);

        // Reset mid-frame, released with ncs still low: remainder must be dropped.
        send_frame(32'h8480, 16, 4);
        begin_frame(4);
        send_bits(32'h84, 8, 4);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        #1 check("async_reset_regs", {dut_regs, reg_wr_pulse}, 41'h0);
        pin_delay(3);
        rst_n = 1'b1;
        pin_delay(4);
        send_bits(32'h11, 8, 4);
        end_frame(1'b0, 4);
        check("after_reset_partial", dut_regs, model_pack());
        send_frame(32'h8422, 16, 4);
        check("duty_after_reset", pwm_duty_cycle, 8'h22);

        send_frame(32'h8010, 16, 4);
        check("b2b_first", en_reg_out_7_0, 8'h10);
        send_frame(32'h8020, 16, 4);
        check("b2b_second", en_reg_out_7_0, 8'h20);

        for (int k = 0; k < 40; k++) begin
            f16 = {($urandom_range(0, 7) != 0), 7'($urandom_range(0, 6)), 8'($urandom)};
            case ($urandom_range(0, 5))
                0:       begin nb = 15; fr = 32'(f16 >> 1);              end
                1:       begin nb = 17; fr = {15'h0, f16, 1'($urandom)}; end
                default: begin nb = 16; fr = 32'(f16);                   end
            endcase
            half = $urandom_range(4, 32);
            send_frame(fr, nb, half);
        end

        pin_delay(4);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
